// File: rtl/reg_pipe.sv
// Elastic register pipeline: DEPTH valid/ready stages with bubble collapsing,
// an occupancy count and a synchronous flush.
module reg_pipe #(
  parameter int unsigned      WIDTH     = 18,
  parameter int unsigned      DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int unsigned     CntW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CntW-1:0]  count
);

  logic [DEPTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] src_d [DEPTH];
  logic [CntW-1:0]  count_q, count_d;
  logic             acc, cons;

  // A stage can take new data when it is empty or its occupant moves on.
  always_comb begin
    logic r;
    r = out_ready;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      rdy[i] = ~v_q[i] | r;
      r      = rdy[i];
    end
  end

  assign in_ready  = rdy[0] & ~clr;
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign count     = count_q;
  assign acc       = in_valid & in_ready;
  assign cons      = out_valid & out_ready;

  always_comb begin
    src_v[0] = in_valid;
    src_d[0] = in_data;
    for (int i = 1; i < int'(DEPTH); i++) begin
      src_v[i] = v_q[i-1];
      src_d[i] = d_q[i-1];
    end
  end

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (clr) begin
      v_d = '0;
      for (int i = 0; i < int'(DEPTH); i++) d_d[i] = RESET_VAL;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (rdy[i]) begin
          v_d[i] = src_v[i];
          // Bubbles keep their old data frozen.
          if (src_v[i]) d_d[i] = src_d[i];
        end
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (acc && !cons) begin
      count_d = count_q + CntW'(1);
    end else if (!acc && cons) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q     <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) d_q[i] <= RESET_VAL;
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      for (int i = 0; i < int'(DEPTH); i++) d_q[i] <= d_d[i];
    end
  end

endmodule

// File: tb/tb_reg_pipe.sv
// Bench for reg_pipe: DEPTH=2 and DEPTH=4 instances share stimulus, each checked
// against a queue-of-beats model that tracks every beat's stage position.
module tb_reg_pipe;
  localparam int W = 18;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic         ir2, ov2, ir4, ov4;
  logic [W-1:0] od2, od4;
  logic [1:0]   cnt2;
  logic [2:0]   cnt4;

  int checks = 0;
  int errors = 0;

  int           dep [2] = '{2, 4};
  logic [W-1:0] rv  [2] = '{18'h00000, 18'h00155};
  int           n   [2];
  int           ent_p [2][8];
  logic [W-1:0] ent_d [2][8];
  logic [W-1:0] last_out [2];
  bit           mv [8];

  reg_pipe #(.WIDTH(W), .DEPTH(2), .RESET_VAL(18'h00000)) dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(ir2),
    .in_data(in_data), .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .count(cnt2)
  );

  reg_pipe #(.WIDTH(W), .DEPTH(4), .RESET_VAL(18'h00155)) dut4 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(ir4),
    .in_data(in_data), .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .count(cnt4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      n[k] = 0;
      last_out[k] = rv[k];
    end
  endtask

  // Beat j (0 = oldest) advances if the slot ahead is free or its holder advances.
  function automatic void calc_moves(input int k, input bit ordy);
    for (int j = 0; j < n[k]; j++) begin
      if (j == 0) mv[j] = (ent_p[k][0] < dep[k] - 1) || ordy;
      else        mv[j] = (ent_p[k][j-1] > ent_p[k][j] + 1) || mv[j-1];
    end
  endfunction

  function automatic bit exp_in_ready(input int k, input bit ordy, input bit c);
    calc_moves(k, ordy);
    if (c) return 1'b0;
    if (n[k] == 0) return 1'b1;
    return (ent_p[k][n[k]-1] > 0) || mv[n[k]-1];
  endfunction

  task automatic model_update(input int k, input bit iv, input logic [W-1:0] din,
                              input bit ordy, input bit c);
    bit ir;
    int m;
    ir = exp_in_ready(k, ordy, c);
    if (c) begin
      n[k] = 0;
      last_out[k] = rv[k];
      return;
    end
    m = 0;
    for (int j = 0; j < n[k]; j++) begin
      if (!(mv[j] && ent_p[k][j] == dep[k] - 1)) begin
        ent_p[k][m] = ent_p[k][j] + int'(mv[j]);
        ent_d[k][m] = ent_d[k][j];
        if (mv[j] && ent_p[k][m] == dep[k] - 1) last_out[k] = ent_d[k][m];
        m++;
      end
    end
    n[k] = m;
    if (iv && ir) begin
      ent_p[k][n[k]] = 0;
      ent_d[k][n[k]] = din;
      if (dep[k] == 1) last_out[k] = din;
      n[k]++;
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, advance the model.
  task automatic step(input bit iv, input logic [W-1:0] din, input bit ordy, input bit c);
    logic [31:0] o_ir, o_ov, o_od, o_cnt;
    in_valid  = iv;
    in_data   = din;
    out_ready = ordy;
    clr       = c;
    #1;
    for (int k = 0; k < 2; k++) begin
      o_ir  = (k == 0) ? 32'(ir2)  : 32'(ir4);
      o_ov  = (k == 0) ? 32'(ov2)  : 32'(ov4);
      o_od  = (k == 0) ? 32'(od2)  : 32'(od4);
      o_cnt = (k == 0) ? 32'(cnt2) : 32'(cnt4);
      check($sformatf("in_ready d%0d", dep[k]), o_ir, 32'(exp_in_ready(k, ordy, c)));
      check($sformatf("out_valid d%0d", dep[k]), o_ov,
            32'(n[k] > 0 && ent_p[k][0] == dep[k] - 1));
      check($sformatf("out_data d%0d", dep[k]), o_od, 32'(last_out[k]));
      check($sformatf("count d%0d", dep[k]), o_cnt, 32'(n[k]));
    end
    for (int k = 0; k < 2; k++) model_update(k, iv, din, ordy, c);
    @(negedge clk);
  endtask

  initial begin
    clr = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state, idle.
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Full-rate stream with downstream always ready.
    for (int i = 1; i <= 8; i++) step(1'b1, W'(i), 1'b1, 1'b0);
    repeat (5) step(1'b0, '0, 1'b1, 1'b0);

    // Backpressure: offer three beats while stalled, then release.
    step(1'b1, 18'h00001, 1'b0, 1'b0);
    step(1'b1, 18'h00002, 1'b0, 1'b0);
    repeat (3) step(1'b1, 18'h00003, 1'b0, 1'b0);
    step(1'b1, 18'h00003, 1'b1, 1'b0);
    repeat (6) step(1'b0, '0, 1'b1, 1'b0);

    // Bubble collapse: one beat at the output, stage 0 empty, still stalled.
    step(1'b1, 18'h00015, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 18'h0002A, 1'b0, 1'b0);
    step(1'b1, 18'h0002B, 1'b0, 1'b0);
    repeat (6) step(1'b0, '0, 1'b1, 1'b0);

    // Flush while full with a beat offered.
    step(1'b1, 18'h00011, 1'b0, 1'b0);
    step(1'b1, 18'h00022, 1'b0, 1'b0);
    step(1'b1, 18'h3FFFF, 1'b0, 1'b1);
    repeat (5) step(1'b0, '0, 1'b1, 1'b0);

    // Fill DEPTH=4, then an asynchronous reset pulse between clock edges.
    for (int i = 0; i < 5; i++) step(1'b1, W'(18'h00100 + i), 1'b0, 1'b0);
    check("full d4 before reset", 32'(cnt4), 32'd4);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst out_valid d4", 32'(ov4), 32'd0);
    check("async rst count d4", 32'(cnt4), 32'd0);
    check("async rst out_data d4", 32'(od4), 32'h155);
    check("async rst out_valid d2", 32'(ov2), 32'd0);
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 6; i++) step(1'b1, W'(18'h00200 + i), 1'b1, 1'b0);
    repeat (6) step(1'b0, '0, 1'b1, 1'b0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, W'($urandom), ($urandom % 3) != 0, ($urandom % 32) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
